pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Central pipeline hold/flush controller, parametrised over pipeline depth. Arbitrates
//   mem/ex wait requests, EX branch-redirects, CLINT interrupt entry and JTAG halt, and
//   drives a 2-bit hold code per pipeline register plus the redirect (jump) bus to PC.
//   Adds an irq-entry handshake, a halt drain/halted FSM and a stall watchdog.
// PARAMETERS
//   STAGES   4   pipeline registers controlled; index 0 = pc, STAGES-1 = last (ex_memwb)
//   EX_IDX   2   index of the register feeding EX (id_ex); 1 <= EX_IDX <= STAGES-2
//   ADDR_W   32  instruction address width
//   CAUSE_W  3   jump cause width
//   CNT_W    8   stall watchdog counter width
//   TIMEOUT  200 consecutive wait cycles that raise stall_timeout_o (< 2^CNT_W)
// PORTS
//   clk                        in   1          clock
//   rst                        in   1          synchronous reset, active-high
//   mem_wb_wr_wait_req_i       in   1          mem/wb busy: freeze whole pipeline
//   ex_multi_clock_wait_req_i  in   1          EX multi-cycle op in progress
//   ex_jump_cause_i            in   CAUSE_W    EX redirect cause
//   ex_jump_from_addr_i        in   ADDR_W     redirecting instruction address
//   ex_jump_to_addr_i          in   ADDR_W     redirect target
//   clint_irq_req_i            in   1          interrupt pending (level, held until ack)
//   clint_irq_epc_i            in   ADDR_W     return address for interrupt
//   clint_irq_vector_i         in   ADDR_W     interrupt handler address
//   clint_irq_ack_o            out  1          one-cycle pulse: interrupt taken
//   jtag_halt_req_i            in   1          debug halt request (level)
//   jtag_halt_ack_o            out  1          1 while pipeline halted and drained
//   hold_ctrl_o                out  2*STAGES   hold code per stage, stage k at [2k+1:2k]
//   jump_cause_o               out  CAUSE_W    redirect cause to PC
//   jump_from_addr_o           out  ADDR_W     redirect source address
//   jump_to_addr_o             out  ADDR_W     redirect target address
//   stall_timeout_o            out  1          watchdog tripped (sticky until wait ends)
// BEHAVIOUR
//   Hold codes: 2'b00 no, 2'b01 wait, 2'b10 flush. Causes: 0 no, 1 pred_yes_but_no,
//   2 pred_no_but_yes, 3 nocondition, 4 irq; other values treated as 0.
//   Jump bus defaults to zero/cause 0 whenever no redirect is issued (combinational).
//   Patterns: MEMW all wait. MULW stages 0..EX_IDX wait, EX_IDX+1 flush, rest no.
//     JMP stage 0 wait, 1..EX_IDX flush, rest no; bus = ex from/to/cause.
//     IRQ as JMP but bus = epc/vector/cause 4. DRN stage 0 wait, 1 flush, rest no.
//     HLT all wait. NONE all no.
//   FSM states RUN, IRQ_ACK, HALT_DRAIN, HALTED; reset -> RUN from any state, mid-op
//   too. Reset values: all registered outputs 0, drain counter 0, watchdog 0.
//   RUN priority: mem wait > multi wait > ex jump (cause 1-3) > irq > halt > NONE.
//     irq selected -> IRQ pattern this cycle, next state IRQ_ACK.
//     halt selected -> DRN pattern this cycle, next HALT_DRAIN, drain counter = 1.
//   IRQ_ACK (1 cycle): clint_irq_ack_o=1; as RUN but irq and halt not accepted; -> RUN.
//   HALT_DRAIN: mem wait > multi wait > ex jump > DRN. Counter increments only on
//     DRN cycles; when it reaches STAGES-1 after increment -> HALTED. irq ignored (pending).
//     jtag_halt_req_i dropping in HALT_DRAIN -> RUN next cycle.
//   HALTED: HLT pattern, jtag_halt_ack_o=1 (registered, i.e. state==HALTED);
//     jtag_halt_req_i=0 -> RUN next cycle; irq stays pending, taken in RUN.
//   Watchdog: counts consecutive cycles where MEMW or MULW pattern chosen, saturating
//     at 2^CNT_W-1; cleared on any other cycle; stall_timeout_o = (count >= TIMEOUT).
//     Not counted in HALTED.
//   Ex jump and irq never both issued in one cycle; jump wins, irq retried next cycle.
// TESTING
//   Reset, idle inputs -> hold_ctrl_o=8'h00, jump bus 0, acks 0, FSM RUN.
//   mem wait + jump cause 3 same cycle -> hold_ctrl_o=8'h55, jump_cause_o=0.
//   multi wait 1 cycle -> 8'h95; jump cause 2 to 0x100 -> 8'h29, to_addr 0x100.
//   irq req, vector 0x80, epc 0x44 -> cycle N 8'h29 cause 4 to 0x80 from 0x44;
//     N+1 ack=1; req held at N+1 not retaken.
//   halt req, STAGES=4 -> 3 DRN cycles (8'h09), one mem wait cycle mid-drain extends
//     by 1, then HLT 8'h55 with halt_ack=1; release -> RUN, 8'h00 next cycle.
//   multi wait held 250 cycles -> stall_timeout_o rises at count 200, clears when
//     wait drops; rst asserted in HALTED -> RUN, halt_ack 0 next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hold/flush controller: wait/flush codes per pipeline register, PC redirect bus,
// irq-entry handshake, debug halt drain/halted FSM and stall watchdog. Hold/jump outputs are combinational.
module pipe_hazard_ctrl #(
  parameter int STAGES  = 4,
  parameter int EX_IDX  = 2,
  parameter int ADDR_W  = 32,
  parameter int CAUSE_W = 3,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_wb_wr_wait_req_i,
  input  logic                  ex_multi_clock_wait_req_i,
  input  logic [CAUSE_W-1:0]    ex_jump_cause_i,
  input  logic [ADDR_W-1:0]     ex_jump_from_addr_i,
  input  logic [ADDR_W-1:0]     ex_jump_to_addr_i,
  input  logic                  clint_irq_req_i,
  input  logic [ADDR_W-1:0]     clint_irq_epc_i,
  input  logic [ADDR_W-1:0]     clint_irq_vector_i,
  output logic                  clint_irq_ack_o,
  input  logic                  jtag_halt_req_i,
  output logic                  jtag_halt_ack_o,
  output logic [2*STAGES-1:0]   hold_ctrl_o,
  output logic [CAUSE_W-1:0]    jump_cause_o,
  output logic [ADDR_W-1:0]     jump_from_addr_o,
  output logic [ADDR_W-1:0]     jump_to_addr_o,
  output logic                  stall_timeout_o
);

  localparam int DW = (STAGES > 2) ? $clog2(STAGES) : 1;

  localparam logic [1:0] H_NO    = 2'b00;
  localparam logic [1:0] H_WAIT  = 2'b01;
  localparam logic [1:0] H_FLUSH = 2'b10;

  typedef enum logic [1:0] {RUN, IRQ_ACK, HALT_DRAIN, HALTED} state_t;
  typedef enum logic [2:0] {P_NONE, P_MEMW, P_MULW, P_JMP, P_IRQ, P_DRN, P_HLT} pat_t;

  state_t            state;
  pat_t              pat;
  logic [DW-1:0]     drain;
  logic [DW-1:0]     drain_inc;
  logic [CNT_W-1:0]  wd;
  logic              jump_ok;
  logic              irq_ack;
  logic              halt_ack;

  // Only causes 1..3 are real EX redirects; anything else is ignored.
  assign jump_ok   = (ex_jump_cause_i >= CAUSE_W'(1)) && (ex_jump_cause_i <= CAUSE_W'(3));
  assign drain_inc = drain + DW'(1);

  always_comb begin
    pat = P_NONE;
    if (state == HALTED)                      pat = P_HLT;
    else if (mem_wb_wr_wait_req_i)            pat = P_MEMW;
    else if (ex_multi_clock_wait_req_i)       pat = P_MULW;
    else if (jump_ok)                         pat = P_JMP;
    else if (state == RUN && clint_irq_req_i) pat = P_IRQ;
    else if (state == RUN && jtag_halt_req_i) pat = P_DRN;
    else if (state == HALT_DRAIN)             pat = P_DRN;
  end

  always_comb begin
    hold_ctrl_o = '0;
    for (int k = 0; k < STAGES; k++) begin
      case (pat)
        P_MEMW, P_HLT: hold_ctrl_o[2*k +: 2] = H_WAIT;
        P_MULW: begin
          if (k <= EX_IDX)          hold_ctrl_o[2*k +: 2] = H_WAIT;
          else if (k == EX_IDX + 1) hold_ctrl_o[2*k +: 2] = H_FLUSH;
          else                      hold_ctrl_o[2*k +: 2] = H_NO;
        end
        P_JMP, P_IRQ: begin
          if (k == 0)            hold_ctrl_o[2*k +: 2] = H_WAIT;
          else if (k <= EX_IDX)  hold_ctrl_o[2*k +: 2] = H_FLUSH;
          else                   hold_ctrl_o[2*k +: 2] = H_NO;
        end
        P_DRN: begin
          if (k == 0)       hold_ctrl_o[2*k +: 2] = H_WAIT;
          else if (k == 1)  hold_ctrl_o[2*k +: 2] = H_FLUSH;
          else              hold_ctrl_o[2*k +: 2] = H_NO;
        end
        default: hold_ctrl_o[2*k +: 2] = H_NO;
      endcase
    end
  end

  always_comb begin
    jump_cause_o     = '0;
    jump_from_addr_o = '0;
    jump_to_addr_o   = '0;
    if (pat == P_JMP) begin
      jump_cause_o     = ex_jump_cause_i;
      jump_from_addr_o = ex_jump_from_addr_i;
      jump_to_addr_o   = ex_jump_to_addr_i;
    end else if (pat == P_IRQ) begin
      jump_cause_o     = CAUSE_W'(4);
      jump_from_addr_o = clint_irq_epc_i;
      jump_to_addr_o   = clint_irq_vector_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      drain    <= '0;
      wd       <= '0;
      irq_ack  <= 1'b0;
      halt_ack <= 1'b0;
    end else begin
      // Consecutive memory/multi-cycle stall length, saturating.
      if (pat == P_MEMW || pat == P_MULW) begin
        if (wd != '1) wd <= wd + CNT_W'(1);
      end else begin
        wd <= '0;
      end
      irq_ack <= 1'b0;
      case (state)
        RUN: begin
          if (pat == P_IRQ) begin
            state   <= IRQ_ACK;
            irq_ack <= 1'b1;
          end else if (pat == P_DRN) begin
            state <= HALT_DRAIN;
            drain <= DW'(1);
          end
        end
        IRQ_ACK: state <= RUN;
        HALT_DRAIN: begin
          if (!jtag_halt_req_i) begin
            state <= RUN;
          end else if (pat == P_DRN) begin
            drain <= drain_inc;
            if (drain_inc == DW'(STAGES - 1)) begin
              state    <= HALTED;
              halt_ack <= 1'b1;
            end
          end
        end
        HALTED: begin
          if (!jtag_halt_req_i) begin
            state    <= RUN;
            halt_ack <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign clint_irq_ack_o = irq_ack;
  assign jtag_halt_ack_o = halt_ack;
  assign stall_timeout_o = (wd >= CNT_W'(TIMEOUT));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl: behavioural model feeds a scoreboard queue,
// a negedge monitor compares every cycle's outputs.
module tb_pipe_hazard_ctrl;

  localparam int STAGES = 4;
  localparam int EX_IDX = 2;
  localparam int TMO    = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_w, mul_w, irq, halt;
  logic [2:0]  cause;
  logic [31:0] from_a, to_a, epc, vec;
  logic        irq_ack, halt_ack, tmo;
  logic [7:0]  hold;
  logic [2:0]  j_cause;
  logic [31:0] j_from, j_to;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_wb_wr_wait_req_i(mem_w), .ex_multi_clock_wait_req_i(mul_w),
    .ex_jump_cause_i(cause), .ex_jump_from_addr_i(from_a), .ex_jump_to_addr_i(to_a),
    .clint_irq_req_i(irq), .clint_irq_epc_i(epc), .clint_irq_vector_i(vec),
    .clint_irq_ack_o(irq_ack), .jtag_halt_req_i(halt), .jtag_halt_ack_o(halt_ack),
    .hold_ctrl_o(hold), .jump_cause_o(j_cause), .jump_from_addr_o(j_from),
    .jump_to_addr_o(j_to), .stall_timeout_o(tmo)
  );

  typedef struct packed {
    logic [7:0]  hold;
    logic [2:0]  cause;
    logic [31:0] from;
    logic [31:0] to;
    logic        iack;
    logic        hack;
    logic        tmo;
  } obs_t;

  obs_t q[$];
  int   checks = 0;
  int   passed = 0;

  // Model state: mode 0 running, 1 irq just taken, 2 draining, 3 halted.
  int m_mode = 0;
  int m_drained = 0;
  int m_stall = 0;

  function automatic logic [1:0] stage_code(int kind, int k);
    // kind: 0 none, 1 memw, 2 mulw, 3 jmp, 4 irq, 5 drn, 6 hlt
    case (kind)
      1, 6: return 2'b01;
      2:    return (k <= EX_IDX) ? 2'b01 : ((k == EX_IDX + 1) ? 2'b10 : 2'b00);
      3, 4: return (k == 0) ? 2'b01 : ((k <= EX_IDX) ? 2'b10 : 2'b00);
      5:    return (k == 0) ? 2'b01 : ((k == 1) ? 2'b10 : 2'b00);
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_cycle();
    obs_t e;
    int   kind;
    bit   jmp;
    jmp = (cause >= 1) && (cause <= 3);
    if (m_mode == 3)                 kind = 6;
    else if (mem_w)                  kind = 1;
    else if (mul_w)                  kind = 2;
    else if (jmp)                    kind = 3;
    else if (m_mode == 0 && irq)     kind = 4;
    else if (m_mode == 0 && halt)    kind = 5;
    else if (m_mode == 2)            kind = 5;
    else                             kind = 0;
    e = '0;
    for (int k = 0; k < STAGES; k++) e.hold[2*k +: 2] = stage_code(kind, k);
    if (kind == 3) begin e.cause = cause; e.from = from_a; e.to = to_a; end
    if (kind == 4) begin e.cause = 3'd4;  e.from = epc;    e.to = vec;  end
    e.iack = (m_mode == 1);
    e.hack = (m_mode == 3);
    e.tmo  = (m_stall >= TMO);
    q.push_back(e);
    if (rst) begin
      m_mode = 0; m_drained = 0; m_stall = 0;
    end else begin
      m_stall = (kind == 1 || kind == 2) ? ((m_stall < 255) ? m_stall + 1 : 255) : 0;
      case (m_mode)
        0: if (kind == 4) m_mode = 1;
           else if (kind == 5) begin m_mode = 2; m_drained = 1; end
        1: m_mode = 0;
        2: if (!halt) m_mode = 0;
           else if (kind == 5) begin
             m_drained++;
             if (m_drained == STAGES - 1) m_mode = 3;
           end
        default: if (!halt) m_mode = 0;
      endcase
    end
  endtask

  task automatic drive(input bit r, input bit mw, input bit uw, input logic [2:0] c,
                       input logic [31:0] t, input bit iq, input bit hl);
    @(posedge clk);
    #1;
    rst = r; mem_w = mw; mul_w = uw; cause = c; to_a = t; irq = iq; halt = hl;
    from_a = 32'h0000_0200; epc = 32'h44; vec = 32'h80;
    model_cycle();
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      obs_t e, a;
      e = q.pop_front();
      a = '{hold, j_cause, j_from, j_to, irq_ack, halt_ack, tmo};
      checks++;
      if (a === e) passed++;
      else $display("FAIL scoreboard @%0t: got hold=%h c=%0d f=%h t=%h ia=%b ha=%b to=%b want hold=%h c=%0d f=%h t=%h ia=%b ha=%b to=%b",
                    $time, a.hold, a.cause, a.from, a.to, a.iack, a.hack, a.tmo,
                    e.hold, e.cause, e.from, e.to, e.iack, e.hack, e.tmo);
    end
  end

  initial begin
    rst = 1'b1; mem_w = 0; mul_w = 0; cause = 0; irq = 0; halt = 0;
    from_a = 0; to_a = 0; epc = 0; vec = 0;
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0); #2;
    chk("reset_hold", 64'(hold), 64'h00);
    chk("reset_acks", {62'b0, irq_ack, halt_ack}, 64'h0);
    chk("reset_bus", {29'b0, j_cause, j_to}, 64'h0);

    drive(0, 1, 0, 3'd3, 32'h300, 0, 0); #2;
    chk("memw_hold", 64'(hold), 64'h55);
    chk("memw_cause", 64'(j_cause), 64'h0);
    drive(0, 0, 1, 0, 0, 0, 0); #2;
    chk("mulw_hold", 64'(hold), 64'h95);
    drive(0, 0, 0, 3'd2, 32'h100, 0, 0); #2;
    chk("jmp_hold", 64'(hold), 64'h29);
    chk("jmp_to", 64'(j_to), 64'h100);

    drive(0, 0, 0, 0, 0, 1, 0); #2;
    chk("irq_hold", 64'(hold), 64'h29);
    chk("irq_bus", {j_cause, j_from, j_to}, {29'b0, 3'd4, 32'h44, 32'h80});
    drive(0, 0, 0, 0, 0, 1, 0); #2;
    chk("irq_ack", 64'(irq_ack), 64'h1);
    chk("irq_not_retaken", 64'(hold), 64'h00);
    drive(0, 0, 0, 0, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 1); #2; chk("drn1", 64'(hold), 64'h09);
    drive(0, 0, 0, 0, 0, 0, 1); #2; chk("drn2", 64'(hold), 64'h09);
    drive(0, 1, 0, 0, 0, 0, 1); #2; chk("drn_memw", 64'(hold), 64'h55);
    drive(0, 0, 0, 0, 0, 0, 1); #2; chk("drn3", 64'(hold), 64'h09);
    chk("drn3_noack", 64'(halt_ack), 64'h0);
    drive(0, 0, 0, 0, 0, 0, 1); #2; chk("hlt_hold", 64'(hold), 64'h55);
    chk("hlt_ack", 64'(halt_ack), 64'h1);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0); #2;
    chk("release_hold", 64'(hold), 64'h00);
    chk("release_ack", 64'(halt_ack), 64'h0);

    for (int i = 1; i <= 250; i++) begin
      drive(0, 0, 1, 0, 0, 0, 0); #2;
      if (i == 200) chk("wd_200", 64'(tmo), 64'h0);
      if (i == 201) chk("wd_201", 64'(tmo), 64'h1);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0); #2;
    chk("wd_clear", 64'(tmo), 64'h0);

    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 1);
    #2; chk("halted_again", 64'(halt_ack), 64'h1);
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0); #2;
    chk("rst_in_halted_ack", 64'(halt_ack), 64'h0);
    chk("rst_in_halted_hold", 64'(hold), 64'h00);

    for (int i = 0; i < 3000; i++) begin
      logic [2:0] c;
      c = ($urandom_range(0, 9) < 3) ? 3'($urandom_range(1, 7)) : 3'd0;
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) == 0), c, $urandom,
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0) && (i % 97 > 30));
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("queue_drained", 64'(q.size()), 64'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
